// File: rtl/imem_stream_loader.sv
// ---------------------------------------------------------------------------
// imem_stream_loader
//
// Boot-time loader that sits in front of the MIPS instruction memory. It takes
// a byte stream made of a 16-bit word count (high byte first) followed by
// big-endian 32-bit instruction words. Each word is written to consecutive
// word addresses starting at 0. The CPU core is held in reset until the whole
// program has arrived intact.
//
// Optional feature macro: IMEM_STREAM_LOADER_CHECKSUM_EN
//   defined   : a trailing checksum byte (XOR of all data bytes) is consumed
//               and compared; a mismatch ends the session in ERROR.
//   undefined : no checksum byte; the session ends in DONE right after the
//               last word (or straight after a zero count).
//
// Ports
//   i_clk          system clock
//   i_rst          asynchronous active-high reset
//   i_start        single-cycle pulse that begins a load session
//   i_byte         stream data byte
//   i_byte_valid   i_byte is valid
//   o_byte_ready   loader can accept a byte (registered)
//   o_imem_we      instruction-memory write strobe, one cycle per word
//   o_imem_addr    instruction-memory word address
//   o_imem_wdata   instruction word
//   o_cpu_rst_n    active-low reset for the CPU core
//   o_done         load completed successfully (level)
//   o_error        load aborted (level)
//   o_word_cnt     number of words written in this session
// ---------------------------------------------------------------------------
module imem_stream_loader #(
    parameter int ADDR_W    = 8,
    parameter int MAX_WORDS = 2 ** ADDR_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [7:0]        i_byte,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_rst_n,
    output logic              o_done,
    output logic              o_error,
    output logic [15:0]       o_word_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        S_CHECK  = 3'd4,
`endif
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    // Where the FSM goes once the data phase is over (or skipped by len==0).
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
    localparam state_t S_AFTER_DATA = S_CHECK;
`else
    localparam state_t S_AFTER_DATA = S_DONE;
`endif

    state_t      r_state;
    state_t      w_next_state;

    logic [7:0]  r_len_hi;
    logic [15:0] r_len;
    logic [23:0] r_asm;
    logic [1:0]  r_byte_idx;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
    logic [7:0]  r_csum;
`endif

    logic        w_accept;
    logic        w_restart;
    logic        w_last_byte;
    logic        w_last_word;
    logic        w_too_long;
    logic        w_ready_next;
    logic [15:0] w_len;
    logic [15:0] w_cnt_inc;

    assign w_accept    = i_byte_valid && o_byte_ready;
    assign w_len       = {r_len_hi, i_byte};
    assign w_too_long  = ({16'd0, w_len} > 32'(MAX_WORDS));
    assign w_cnt_inc   = o_word_cnt + 16'd1;
    assign w_last_byte = (r_byte_idx == 2'd3);
    assign w_last_word = (w_cnt_inc == r_len);
    assign w_restart   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                     (r_state == S_ERROR));

    // Ready is registered from the next state so it is already high in the
    // first cycle of a byte-consuming state and low in the first cycle after.
    always_comb begin
        w_ready_next = 1'b0;
        case (w_next_state)
            S_LEN_HI, S_LEN_LO, S_DATA: w_ready_next = 1'b1;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            S_CHECK:                    w_ready_next = 1'b1;
`endif
            default:                    w_ready_next = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next_state = S_LEN_HI;
            end
            S_LEN_HI: begin
                if (w_accept) w_next_state = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_accept) begin
                    if (w_too_long)            w_next_state = S_ERROR;
                    else if (w_len == 16'd0)   w_next_state = S_AFTER_DATA;
                    else                       w_next_state = S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept && w_last_byte && w_last_word) w_next_state = S_AFTER_DATA;
            end
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (w_accept) w_next_state = (i_byte == r_csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (i_start) w_next_state = S_LEN_HI;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath and registered outputs. The write strobe, address, data and
    // word count are all loaded on the edge that takes a word's 4th byte, so
    // they appear together one cycle after that byte is accepted.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_byte_ready <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= 32'd0;
            o_cpu_rst_n  <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_word_cnt   <= 16'd0;
            r_len_hi     <= 8'd0;
            r_len        <= 16'd0;
            r_asm        <= 24'd0;
            r_byte_idx   <= 2'd0;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            r_csum       <= 8'd0;
`endif
        end else begin
            o_imem_we    <= 1'b0;
            o_byte_ready <= w_ready_next;
            o_done       <= (w_next_state == S_DONE);
            o_error      <= (w_next_state == S_ERROR);
            o_cpu_rst_n  <= (w_next_state == S_DONE);

            if (w_restart) begin
                o_word_cnt <= 16'd0;
                r_byte_idx <= 2'd0;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
                r_csum     <= 8'd0;
`endif
            end

            if (w_accept) begin
                case (r_state)
                    S_LEN_HI: r_len_hi <= i_byte;
                    S_LEN_LO: r_len    <= w_len;
                    S_DATA: begin
                        r_asm      <= {r_asm[15:0], i_byte};
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
                        r_csum     <= r_csum ^ i_byte;
`endif
                        if (w_last_byte) begin
                            o_imem_we    <= 1'b1;
                            o_imem_addr  <= o_word_cnt[ADDR_W-1:0];
                            o_imem_wdata <= {r_asm, i_byte};
                            o_word_cnt   <= w_cnt_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_stream_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_stream_loader
//
// Self-checking bench for imem_stream_loader. Streams are built as byte
// queues; a reference model parses the whole stream to predict the words,
// addresses, final status and word count. A monitor records every write
// strobe with its cycle number so write latency and ordering against o_done
// can be checked. Works with or without IMEM_STREAM_LOADER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_imem_stream_loader;

    localparam int ADDR_W    = 8;
    localparam int MAX_WORDS = 2 ** ADDR_W;

    typedef logic [ADDR_W+31:0] wr_t;

    logic              i_clk;
    logic              i_rst;
    logic              i_start;
    logic [7:0]        i_byte;
    logic              i_byte_valid;
    logic              o_byte_ready;
    logic              o_imem_we;
    logic [ADDR_W-1:0] o_imem_addr;
    logic [31:0]       o_imem_wdata;
    logic              o_cpu_rst_n;
    logic              o_done;
    logic              o_error;
    logic [15:0]       o_word_cnt;

    imem_stream_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_cpu_rst_n  (o_cpu_rst_n),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_word_cnt   (o_word_cnt)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int passCount = 0;
    int failCount = 0;
    int checkCount = 0;

    logic [7:0] stream[$];
    wr_t        expWr[$];
    wr_t        gotWr[$];
    wr_t        refWr[$];
    int         expCyc[$];
    int         gotCyc[$];
    int         doneCyc = -1;
    int         readyDrops;
    bit         expDone;
    bit         expError;
    int         expCnt;

    // Records every write strobe and the first cycle o_done is seen high.
    always @(negedge i_clk) begin
        if (o_imem_we) begin
            gotWr.push_back({o_imem_addr, o_imem_wdata});
            gotCyc.push_back(cyc);
        end
        if (o_done && doneCyc < 0) doneCyc = cyc;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) begin
            passCount++;
        end else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 64'(o_byte_ready), 64'd0);
        checkOutput({tag, "_we"},    64'(o_imem_we),    64'd0);
        checkOutput({tag, "_addr"},  64'(o_imem_addr),  64'd0);
        checkOutput({tag, "_wdata"}, 64'(o_imem_wdata), 64'd0);
        checkOutput({tag, "_rstn"},  64'(o_cpu_rst_n),  64'd0);
        checkOutput({tag, "_done"},  64'(o_done),       64'd0);
        checkOutput({tag, "_error"}, 64'(o_error),      64'd0);
        checkOutput({tag, "_cnt"},   64'(o_word_cnt),   64'd0);
    endtask

    task automatic pushLen(input int len);
        logic [15:0] l;
        l = 16'(len);
        stream.push_back(l[15:8]);
        stream.push_back(l[7:0]);
    endtask

    task automatic pushWord(input logic [31:0] w);
        stream.push_back(w[31:24]);
        stream.push_back(w[23:16]);
        stream.push_back(w[15:8]);
        stream.push_back(w[7:0]);
    endtask

    // Trailing checksum: XOR of every byte after the two length bytes.
    task automatic appendChecksum(input bit corrupt);
        logic [7:0] x;
        x = 8'd0;
        for (int k = 2; k < stream.size(); k++) x ^= stream[k];
        if (corrupt) x ^= 8'($urandom_range(1, 255));
        stream.push_back(x);
    endtask

    // Reference model: parse the complete stream and predict the session.
    task automatic buildExpected();
        int len;
        logic [7:0] x;
        expWr.delete();
        expDone  = 0;
        expError = 0;
        expCnt   = 0;
        len = int'({stream[0], stream[1]});
        if (len > MAX_WORDS) begin
            expError = 1;
            return;
        end
        x = 8'd0;
        for (int w = 0; w < len; w++) begin
            expWr.push_back({ADDR_W'(w), stream[2+4*w], stream[3+4*w],
                             stream[4+4*w], stream[5+4*w]});
            for (int b = 0; b < 4; b++) x ^= stream[2+4*w+b];
        end
        expCnt = len;
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        if (stream[2+4*len] == x) expDone = 1;
        else                      expError = 1;
`else
        expDone = 1;
`endif
    endtask

    task automatic startSession();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    // Drives the stream; when a word's last byte is handed over the write is
    // expected on the cycle following that edge.
    task automatic applyStimulus(input string tag, input bit gaps);
        int idx;
        int spent;
        int n;
        int lenW;
        idx = 0;
        spent = 0;
        n = stream.size();
        lenW = (n >= 2) ? int'({stream[0], stream[1]}) : 0;
        readyDrops = 0;
        while (idx < n && spent < 4 * n + 200) begin
            @(negedge i_clk);
            spent++;
            if (!o_byte_ready) readyDrops++;
            if (gaps && $urandom_range(0, 2) == 0) begin
                i_byte_valid = 1'b0;
            end else begin
                i_byte_valid = 1'b1;
                i_byte = stream[idx];
                if (o_byte_ready) begin
                    if (idx >= 2 && idx < 2 + 4 * lenW && ((idx - 2) % 4) == 3)
                        expCyc.push_back(cyc + 1);
                    idx++;
                end
            end
        end
        @(negedge i_clk);
        i_byte_valid = 1'b0;
        checkOutput({tag, "_consumed"}, 64'(idx), 64'(n));
        checkOutput({tag, "_ready_held"}, 64'(readyDrops), 64'd0);
    endtask

    task automatic checkSession(input string tag);
        checkOutput({tag, "_nwrites"}, 64'(gotWr.size()), 64'(expWr.size()));
        for (int k = 0; k < expWr.size() && k < gotWr.size(); k++)
            checkOutput($sformatf("%s_write%0d", tag, k), 64'(gotWr[k]), 64'(expWr[k]));
        for (int k = 0; k < expCyc.size() && k < gotCyc.size(); k++)
            checkOutput($sformatf("%s_latency%0d", tag, k), 64'(gotCyc[k]), 64'(expCyc[k]));
        checkOutput({tag, "_done"},  64'(o_done),      64'(expDone));
        checkOutput({tag, "_error"}, 64'(o_error),     64'(expError));
        checkOutput({tag, "_rstn"},  64'(o_cpu_rst_n), 64'(expDone));
        checkOutput({tag, "_cnt"},   64'(o_word_cnt),  64'(expCnt));
        checkOutput({tag, "_ready_off"}, 64'(o_byte_ready), 64'd0);
        if (expDone && gotCyc.size() > 0)
            checkOutput({tag, "_done_order"}, 64'(doneCyc >= gotCyc[gotCyc.size()-1]), 64'd1);
    endtask

    task automatic runSession(input string tag, input bit gaps);
        buildExpected();
        startSession();
        gotWr.delete();
        gotCyc.delete();
        expCyc.delete();
        doneCyc = -1;
        applyStimulus(tag, gaps);
        repeat (2) @(negedge i_clk);
        checkSession(tag);
    endtask

    initial begin
        int n;
        bit gaps;
        logic [7:0] partial[$];

        i_rst = 1'b1;
        i_start = 1'b0;
        i_byte = 8'd0;
        i_byte_valid = 1'b0;
        repeat (3) @(negedge i_clk);
        checkResetValues("reset");
        i_rst = 1'b0;
        i_byte_valid = 1'b1;
        repeat (2) @(negedge i_clk);
        checkOutput("idle_no_start_ready", 64'(o_byte_ready), 64'd0);
        i_byte_valid = 1'b0;

        // Directed program from the plan, good trailer.
        stream.delete();
        pushLen(2);
        pushWord(32'h20080005);
        pushWord(32'hAC080014);
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        appendChecksum(1'b0);
`endif
        runSession("plan_good", 1'b0);

`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        // Same words, wrong checksum byte.
        stream.delete();
        pushLen(2);
        pushWord(32'h20080005);
        pushWord(32'hAC080014);
        stream.push_back(8'h00);
        runSession("plan_badsum", 1'b0);
`endif

        // One word over capacity.
        stream.delete();
        pushLen(16'h0101);
        runSession("over_len", 1'b0);

        // Empty program.
        stream.delete();
        pushLen(0);
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        stream.push_back(8'h00);
`endif
        runSession("len_zero", 1'b0);

        // Exactly full capacity: addresses 0..MAX_WORDS-1.
        stream.delete();
        pushLen(MAX_WORDS);
        for (int w = 0; w < MAX_WORDS; w++) pushWord($urandom);
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        appendChecksum(1'b0);
`endif
        runSession("len_max", 1'b0);

        // Three words without and with valid gaps must write identically.
        stream.delete();
        pushLen(3);
        repeat (3) pushWord($urandom);
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        appendChecksum(1'b0);
`endif
        runSession("three_gapless", 1'b0);
        refWr = gotWr;
        runSession("three_gaps", 1'b1);
        checkOutput("gap_same_nwrites", 64'(gotWr.size()), 64'(refWr.size()));
        for (int k = 0; k < refWr.size() && k < gotWr.size(); k++)
            checkOutput($sformatf("gap_same_write%0d", k), 64'(gotWr[k]), 64'(refWr[k]));

        // Reset after 2 of the 4 bytes of word 1, then a clean reload.
        stream.delete();
        pushLen(2);
        pushWord(32'h8C090000);
        pushWord(32'h01095020);
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
        appendChecksum(1'b0);
`endif
        partial = stream;
        stream = partial[0:7];
        startSession();
        applyStimulus("rst_partial", 1'b0);
        #2;
        i_rst = 1'b1;
        #1;
        checkResetValues("async_reset");
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        checkOutput("post_reset_idle_ready", 64'(o_byte_ready), 64'd0);
        stream = partial;
        runSession("after_reset", 1'b0);

`ifndef IMEM_STREAM_LOADER_CHECKSUM_EN
        // Without a checksum the session ends right after the write and a
        // further byte is left hanging.
        stream.delete();
        pushLen(1);
        pushWord(32'h00000000);
        runSession("nosum_one", 1'b0);
        if (gotCyc.size() == 1)
            checkOutput("nosum_done_lag",
                        64'((doneCyc >= gotCyc[0]) && (doneCyc <= gotCyc[0] + 1)), 64'd1);
        i_byte = 8'h5A;
        i_byte_valid = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            checkOutput("nosum_extra_ready", 64'(o_byte_ready), 64'd0);
        end
        i_byte_valid = 1'b0;
        checkOutput("nosum_extra_nwrites", 64'(gotWr.size()), 64'd1);
        checkOutput("nosum_extra_done", 64'(o_done), 64'd1);
        checkOutput("nosum_extra_cnt", 64'(o_word_cnt), 64'd1);
`endif

        // Randomized sessions: random length, words, gaps and trailer.
        for (int t = 0; t < 8; t++) begin
            n = $urandom_range(1, 6);
            gaps = 1'($urandom_range(0, 1));
            stream.delete();
            pushLen(n);
            repeat (n) pushWord($urandom);
`ifdef IMEM_STREAM_LOADER_CHECKSUM_EN
            appendChecksum($urandom_range(0, 3) == 0);
`endif
            runSession($sformatf("rand%0d", t), gaps);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
